// File: rtl/fp_cvt_arbiter.sv
// fp_cvt_arbiter: round-robin sharing of one fixed-latency FP64->FP96 converter among NREQ requesters
module fp_cvt_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [64*NREQ-1:0]          req_data,
   output logic [NREQ-1:0]             req_ready,
   output logic                        cvt_vld,
   output logic [63:0]                 cvt_i,
   input  logic [95:0]                 cvt_o,
   output logic [NREQ-1:0]             resp_valid,
   output logic [96*NREQ-1:0]          resp_data,
   input  logic [NREQ-1:0]             resp_ready,
   output logic [$clog2(NREQ+1)-1:0]   inflight,
   output logic                        idle
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(NREQ + 1);
   logic [IW-1:0] rr_q, rr_d, win;
   logic [IW:0] j;
   logic found;
   logic [NREQ-1:0] busy_q, busy_d, res_vld_q, res_vld_d, elig, cap_oh, rel;
   logic [NREQ-1:0][95:0] res_q, res_d;
   logic [LAT-1:0] tv_q, tv_d;
   logic [LAT-1:0][IW-1:0] ti_q, ti_d;
   always_comb begin
      elig = req_valid & ~busy_q;
      found = 1'b0;
      win = '0;
      j = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = {1'b0, rr_q} + (IW+1)'(i);
         j = (j >= (IW+1)'(NREQ)) ? j - (IW+1)'(NREQ) : j;
         if (elig[j[IW-1:0]]) begin
            found = 1'b1;
            win = j[IW-1:0];
         end
      end
      req_ready = found ? (NREQ'(1) << win) : '0;
      cvt_vld = found;
      cvt_i = req_data[64*win +: 64];
      rr_d = found ? ((win == IW'(NREQ - 1)) ? '0 : win + IW'(1)) : rr_q;
      tv_d[0] = found;
      ti_d[0] = win;
      for (int i = 1; i < LAT; i++) begin
         tv_d[i] = tv_q[i-1];
         ti_d[i] = ti_q[i-1];
      end
      cap_oh = tv_q[LAT-1] ? (NREQ'(1) << ti_q[LAT-1]) : '0;
      rel = res_vld_q & resp_ready & ~cap_oh;
      busy_d = (busy_q & ~rel) | req_ready;
      res_vld_d = (res_vld_q & ~rel) | cap_oh;
      res_d = res_q;
      if (tv_q[LAT-1]) res_d[ti_q[LAT-1]] = cvt_o;
      inflight = '0;
      for (int k = 0; k < NREQ; k++) inflight = inflight + CW'(busy_q[k]);
      idle = ~|busy_q;
      resp_valid = res_vld_q;
      resp_data = res_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
         busy_q <= '0;
         res_vld_q <= '0;
         res_q <= '0;
         tv_q <= '0;
         ti_q <= '0;
      end else begin
         rr_q <= rr_d;
         busy_q <= busy_d;
         res_vld_q <= res_vld_d;
         res_q <= res_d;
         tv_q <= tv_d;
         ti_q <= ti_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(|(cap_oh & res_vld_q & resp_ready)));
   end
endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// tb_fp_cvt_arbiter: scoreboard bench with a behavioural fixed-latency FP64->FP96 converter
module tb_fp_cvt_arbiter;
   localparam int NREQ = 4;
   localparam int LAT = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NREQ-1:0] req_valid = '0;
   logic [NREQ-1:0] resp_ready = '0;
   logic [64*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0] req_ready, resp_valid;
   logic cvt_vld, idle;
   logic [63:0] cvt_i;
   logic [95:0] cvt_o;
   logic [96*NREQ-1:0] resp_data;
   logic [2:0] inflight;
   logic [LAT-1:0][95:0] cvt_pipe;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit sb_on = 1'b0;
   logic [NREQ-1:0] prev_rv = '0;
   typedef struct { int idx; logic [95:0] res; int cyc; } exp_t;
   exp_t sbq[$];

   fp_cvt_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cvt_vld(cvt_vld), .cvt_i(cvt_i), .cvt_o(cvt_o), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_ready(resp_ready), .inflight(inflight), .idle(idle)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [95:0] fcvt(input logic [63:0] x);
      logic [14:0] e;
      e = (x[62:52] == 11'h7FF) ? 15'h7FFF : (x[62:52] == 11'h0) ? 15'h0 : 15'(x[62:52]) + 15'h3C00;
      return {x[63], e, x[51:0], 28'h0};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   always @(posedge clk) begin
      cvt_pipe[0] <= cvt_vld ? fcvt(cvt_i) : {$urandom, $urandom, $urandom};
      for (int i = 1; i < LAT; i++) cvt_pipe[i] <= cvt_pipe[i-1];
   end
   assign cvt_o = cvt_pipe[LAT-1];

   always @(negedge clk) begin : mon
      exp_t e;
      if (sb_on) begin
         total++;
         if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0 || cvt_vld !== (|req_ready)) begin
            bad++;
            $display("FAIL grant_onehot: req_ready=%b req_valid=%b cvt_vld=%b", req_ready, req_valid, cvt_vld);
         end
         for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && req_ready[k]) sbq.push_back('{k, fcvt(req_data[64*k +: 64]), cyc});
            if (resp_valid[k] && !prev_rv[k]) begin
               total++;
               if (sbq.size() == 0) begin
                  bad++;
                  $display("FAIL sb_empty: resp_valid[%0d] rose at cycle %0d, nothing expected", k, cyc);
               end else begin
                  e = sbq.pop_front();
                  if (e.idx != k || e.res !== resp_data[96*k +: 96] || cyc != e.cyc + LAT + 1) begin
                     bad++;
                     $display("FAIL sb_resp: got req %0d data %h cycle %0d, want req %0d data %h cycle %0d",
                              k, resp_data[96*k +: 96], cyc, e.idx, e.res, e.cyc + LAT + 1);
                  end
               end
            end
         end
      end
      prev_rv = resp_valid;
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int n);
      req_valid = '0;
      resp_ready = '1;
      repeat (n) next();
   endtask

   task automatic do_reset();
      sb_on = 1'b0;
      req_valid = '0;
      resp_ready = '0;
      next();
      rst_n = 1'b0;
      next();
      rst_n = 1'b1;
      sbq.delete();
      sb_on = 1'b1;
   endtask

   task automatic test_reset();
      sb_on = 1'b0;
      req_valid = '0;
      resp_ready = '0;
      next();
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (req_ready !== '0 || cvt_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset_issue: req_ready=%b cvt_vld=%b want 0000 0", req_ready, cvt_vld);
      end
      total++;
      if (resp_valid !== '0) begin bad++; $display("FAIL reset_resp: resp_valid=%b want 0000", resp_valid); end
      total++;
      if (inflight !== 3'd0 || idle !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle: inflight=%0d idle=%b want 0 1", inflight, idle);
      end
      next();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (resp_valid !== '0 || idle !== 1'b1 || req_ready !== '0) begin
         bad++;
         $display("FAIL reset_release: resp_valid=%b idle=%b req_ready=%b", resp_valid, idle, req_ready);
      end
      next();
   endtask

   task automatic test_single();
      logic [63:0] d = 64'h3FF0000000000000;
      logic [NREQ-1:0] ev;
      do_reset();
      req_valid = 4'b0001;
      req_data[63:0] = d;
      resp_ready = 4'b0001;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001 || cvt_vld !== 1'b1 || cvt_i !== d) begin
         bad++;
         $display("FAIL single_issue: req_ready=%b cvt_vld=%b cvt_i=%h want 0001 1 %h", req_ready, cvt_vld, cvt_i, d);
      end
      next();
      req_valid = '0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         ev = (c == 3) ? 4'b0001 : 4'b0000;
         total++;
         if (resp_valid !== ev) begin bad++; $display("FAIL single_rv c%0d: got %b want %b", c, resp_valid, ev); end
         total++;
         if (idle !== (c == 4) || inflight !== ((c == 4) ? 3'd0 : 3'd1)) begin
            bad++;
            $display("FAIL single_busy c%0d: idle=%b inflight=%0d", c, idle, inflight);
         end
         if (c == 3) begin
            total++;
            if (resp_data[95:0] !== 96'h3FFF_0000000000000000_0000) begin
               bad++;
               $display("FAIL single_data: got %h want 3fff00000000000000000000", resp_data[95:0]);
            end
         end
         next();
      end
   endtask

   task automatic test_all_four();
      logic [NREQ-1:0] pend, eg, ev;
      do_reset();
      pend = '1;
      for (int c = 0; c < 16; c++) begin
         if (c == 8) pend = '1;
         if (c == 0 || c == 8) for (int k = 0; k < NREQ; k++) req_data[64*k +: 64] = rnd64();
         req_valid = pend;
         resp_ready = (c >= 7) ? '1 : '0;
         @(negedge clk);
         eg = (c < 4) ? (NREQ'(1) << c) : (c >= 8 && c < 12) ? (NREQ'(1) << (c - 8)) : '0;
         ev = (c < 3 || c > 7) ? '0 : NREQ'((1 << (c - 2)) - 1);
         total++;
         if (req_ready !== eg) begin bad++; $display("FAIL all4_grant c%0d: got %b want %b", c, req_ready, eg); end
         if (c <= 8) begin
            total++;
            if (resp_valid !== ev) begin bad++; $display("FAIL all4_rv c%0d: got %b want %b", c, resp_valid, ev); end
         end
         if (c <= 7) begin
            total++;
            if (inflight !== 3'((c > 4) ? 4 : c)) begin
               bad++;
               $display("FAIL all4_inflight c%0d: got %0d want %0d", c, inflight, (c > 4) ? 4 : c);
            end
         end
         pend &= ~(req_valid & req_ready);
         next();
      end
      drain(4);
   endtask

   task automatic test_backpressure();
      int cnt [NREQ];
      logic [NREQ-1:0] hs;
      do_reset();
      cnt = '{default: 0};
      for (int k = 0; k < NREQ; k++) req_data[64*k +: 64] = rnd64();
      for (int c = 0; c < 27; c++) begin
         req_valid = (c < 20) ? 4'b1111 : 4'b0010;
         resp_ready = (c == 24) ? 4'b1111 : 4'b1101;
         @(negedge clk);
         total++;
         if (c == 1 || c == 25) begin
            if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1 c%0d: got %b want 0010", c, req_ready); end
         end else if (req_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL bp_blocked c%0d: req_ready[1]=%b want 0", c, req_ready[1]);
         end
         if (c == 24) begin
            total++;
            if (resp_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_hold: resp_valid[1]=%b want 1", resp_valid[1]); end
         end
         hs = req_valid & req_ready;
         for (int k = 0; k < NREQ; k++) if (hs[k]) cnt[k]++;
         next();
         for (int k = 0; k < NREQ; k++) if (hs[k]) req_data[64*k +: 64] = rnd64();
      end
      drain(6);
      for (int k = 0; k < NREQ; k++) begin
         if (k != 1) begin
            total++;
            if (cnt[k] < 3) begin bad++; $display("FAIL bp_others: requester %0d granted %0d times, want >=3", k, cnt[k]); end
         end
      end
   endtask

   task automatic test_fairness();
      int last, n0, n2, g;
      logic [NREQ-1:0] pend, hs, eg;
      do_reset();
      for (int k = 0; k < NREQ; k++) req_data[64*k +: 64] = rnd64();
      req_valid = 4'b0010;
      resp_ready = '1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin bad++; $display("FAIL tie_pre: got %b want 0010", req_ready); end
      next();
      pend = 4'b0101;
      for (int c = 1; c < 4; c++) begin
         req_valid = pend;
         @(negedge clk);
         eg = (c == 1) ? 4'b0100 : (c == 2) ? 4'b0001 : 4'b0000;
         total++;
         if (req_ready !== eg) begin bad++; $display("FAIL tie_grant c%0d: got %b want %b", c, req_ready, eg); end
         pend &= ~(req_valid & req_ready);
         next();
      end
      drain(5);
      last = -1;
      n0 = 0;
      n2 = 0;
      for (int c = 0; c < 30; c++) begin
         req_valid = 4'b0101;
         resp_ready = '1;
         @(negedge clk);
         hs = req_valid & req_ready;
         if (|hs) begin
            g = hs[0] ? 0 : 2;
            total++;
            if ((hs !== 4'b0001 && hs !== 4'b0100) || g == last) begin
               bad++;
               $display("FAIL fair_alt c%0d: grant %b after requester %0d", c, hs, last);
            end
            last = g;
            n0 += int'(hs[0]);
            n2 += int'(hs[2]);
         end
         next();
         for (int k = 0; k < NREQ; k++) if (hs[k]) req_data[64*k +: 64] = rnd64();
      end
      total++;
      if (n0 < 7 || n2 < 7 || n0 - n2 > 1 || n2 - n0 > 1) begin
         bad++;
         $display("FAIL fair_count: n0=%0d n2=%0d want both >=7 and within 1", n0, n2);
      end
      drain(5);
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < NREQ; k++) req_data[64*k +: 64] = rnd64();
      req_valid = 4'b0011;
      resp_ready = '1;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_mid_g0: got %b want 0001", req_ready); end
      next();
      req_valid = 4'b0010;
      @(negedge clk);
      total++;
      if (req_ready !== 4'b0010) begin bad++; $display("FAIL rst_mid_g1: got %b want 0010", req_ready); end
      next();
      sb_on = 1'b0;
      req_valid = '0;
      rst_n = 1'b0;
      next();
      rst_n = 1'b1;
      sbq.delete();
      sb_on = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         total++;
         if (resp_valid !== '0 || inflight !== 3'd0 || idle !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid c%0d: resp_valid=%b inflight=%0d idle=%b want 0000 0 1", c, resp_valid, inflight, idle);
         end
         next();
      end
   endtask

   task automatic test_passthrough();
      logic [NREQ-1:0] pend;
      do_reset();
      req_data[64*2 +: 64] = 64'h7FF8000000000001;
      req_data[64*3 +: 64] = 64'hFFF0000000000000;
      pend = 4'b1100;
      resp_ready = '1;
      for (int c = 0; c < 6; c++) begin
         req_valid = pend;
         @(negedge clk);
         if (c == 3) begin
            total++;
            if (resp_valid !== 4'b0100 || resp_data[96*2 +: 96] !== 96'h7FFF_8000000000001000_0000) begin
               bad++;
               $display("FAIL pass_nan: rv=%b data=%h want 0100 7fff80000000000010000000", resp_valid, resp_data[96*2 +: 96]);
            end
         end
         if (c == 4) begin
            total++;
            if (resp_valid !== 4'b1000 || resp_data[96*3 +: 96] !== 96'hFFFF_0000000000000000_0000) begin
               bad++;
               $display("FAIL pass_ninf: rv=%b data=%h want 1000 ffff00000000000000000000", resp_valid, resp_data[96*3 +: 96]);
            end
         end
         pend &= ~(req_valid & req_ready);
         next();
      end
      drain(3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_fairness();
      test_reset_mid();
      test_passthrough();
      total++;
      if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d results never delivered", sbq.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fp_cvt_arbiter.md
Name: fp_cvt_arbiter

Overview:
Shares one pipelined fpCvt64To96-class converter (FP64 in, FP96 out, fixed latency) among NREQ requesters. It does round-robin issue of at most one operand per cycle and carries a requester tag alongside the converter pipeline. Results are steered into a per-requester result register with valid/ready backpressure. It sits between the scalar issue ports and the shared format-conversion datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 2, converter latency in cycles, issue to cvt_o valid (1..8)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester k has an FP64 operand
req_data  in  64*NREQ  operand k in bits [64k+63:64k]
req_ready  out  NREQ  grant; a handshake occurs when req_valid[k] and req_ready[k] are both high
cvt_vld  out  1  operand valid to converter
cvt_i  out  64  operand to converter
cvt_o  in  96  converter result, valid LAT cycles after cvt_vld
resp_valid  out  NREQ  result k available
resp_data  out  96*NREQ  result k
resp_ready  in  NREQ  requester k accepts its result
inflight  out  clog2(NREQ+1)  count of busy requesters
idle  out  1  no requester busy

Behaviour:
- Reset (async assert, sync release): rr_ptr=0; busy=0; res_vld=0; tag pipe all invalid; res registers 0. Consequently req_ready=0, cvt_vld=0, resp_valid=0, inflight=0, idle=1.
- Eligibility: elig[k] = req_valid[k] & ~busy[k]. busy is registered, so a slot freed this cycle can be granted next cycle at the earliest.
- Arbitration: combinational. The winner is the first eligible k scanning rr_ptr, rr_ptr+1, … modulo NREQ. req_ready is one-hot on the winner, or zero if no requester is eligible. req_ready never depends on resp_ready.
- Issue cycle: cvt_vld=1 and cvt_i=req_data[winner], both combinational. On the edge: busy[winner]<=1, rr_ptr<=(winner+1) mod NREQ, and tag pipe stage 0 <= {1, winner}. rr_ptr holds when there is no grant.
- Tag pipe: LAT stages of {v, idx}, shifted every cycle without stall. The converter never stalls, and stalling is never needed because every in-flight op already owns an empty result slot.
- Capture: when tag stage LAT-1 is valid, res[idx]<=cvt_o and res_vld[idx]<=1 on that edge. The result appears on resp_valid LAT+1 cycles after the issue edge, i.e. issue at cycle t gives resp_valid at t+LAT+1.
- Response: resp_valid[k]=res_vld[k] and resp_data[k]=res[k]. When resp_valid[k] & resp_ready[k]: res_vld[k]<=0 and busy[k]<=0.
- Capture and release for the same k cannot coincide, because busy blocks any second issue. If this is ever detected, capture wins; flag it as an assertion in simulation.
- Throughput: one issue per cycle; at most one outstanding op per requester; NREQ ops in flight at most.
- inflight = popcount(busy); idle = (busy==0).
- The block is data-agnostic: NaN, infinity and sign handling belong to the converter, and cvt_o is forwarded bit-exact.
- Reset mid-operation: all in-flight ops are discarded and no stale resp_valid appears after rst_n release. The converter output is ignored because the tag pipe is invalid.
- resp_ready held low blocks only that requester. The other requesters continue at full rate.

Test Plan:
- Single op, LAT=2: req_valid[0]=1 with 64'h3FF0000000000000 at cycle 0 -> req_ready[0]=1 and cvt_vld=1 at cycle 0; resp_valid[0]=1 at cycle 3 with 96'h3FFF_0000000000000000_0000 (from the converter model); with resp_ready[0]=1 it drops at cycle 4, and idle returns to 1.
- All four request at cycle 0 -> grants 0,1,2,3 on cycles 0..3, rr_ptr wraps to 0; resp_valid asserts in order on cycles 3..6; inflight peaks at 4.
- Backpressure: requester 1 holds resp_ready=0 and keeps req_valid=1 -> req_ready[1] stays 0 while requesters 0, 2 and 3 keep issuing every cycle; one cycle after resp_ready[1] pulses, requester 1 is granted again.
- Fairness: requesters 0 and 2 request continuously with immediate resp_ready -> grants alternate 0,2,0,2; neither requester is granted twice in a row while the other is eligible.
- Reset mid-flight: issue to requesters 0 and 1, then assert rst_n=0 for 1 cycle before capture -> after release, resp_valid=0 for 10 cycles, inflight=0 and idle=1.
- Pass-through: operand 64'h7FF8000000000001 (NaN) -> resp_data equals the converter's cvt_o exactly (96'h7FFF_8000000000001000_0000).
